// File: rtl/led_pattern_sched.sv
// led_pattern_sched: sequences a 4-bit LED bank (1 = lit) under commands
// from two sources (A: key panel, B: host/debug) that share the block through
// a round-robin valid/ready arbiter. Commands set the pattern mode, the step
// rate and a pause flag; a prescaler paces the pattern steps.
module led_pattern_sched #(
  parameter int unsigned TICK_BASE = 25_000_000,
  parameter int unsigned MODE_RST  = 3,
  parameter int unsigned SPEED_RST = 0
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       a_valid,
  input  logic [1:0] a_op,
  input  logic [2:0] a_arg,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [1:0] b_op,
  input  logic [2:0] b_arg,
  output logic       b_ready,
  output logic [3:0] led,
  output logic [2:0] mode_o,
  output logic [1:0] speed_o,
  output logic       paused_o,
  output logic       tick_o,
  output logic       err_o
);

  localparam int unsigned CW = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;

  typedef enum logic [1:0] {
    OP_SET_MODE  = 2'd0,
    OP_SPEED     = 2'd1,
    OP_PAUSE     = 2'd2,
    OP_NEXT_MODE = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    M_OFF   = 3'd0,
    M_SHL   = 3'd1,
    M_SHR   = 3'd2,
    M_PING  = 3'd3,
    M_BLINK = 3'd4
  } mode_e;

  localparam mode_e MODE_RST_E = mode_e'(3'(MODE_RST));

  // Pattern value loaded whenever a mode is (re)entered.
  function automatic logic [3:0] entry_led(input mode_e m);
    case (m)
      M_OFF:   entry_led = 4'b0000;
      M_SHR:   entry_led = 4'b1000;
      M_BLINK: entry_led = 4'b1111;
      default: entry_led = 4'b0001;
    endcase
  endfunction

  // Registered state and its next-state values.
  mode_e         mode_q, mode_d;
  logic [3:0]    led_q, led_d;
  logic          dir_l_q, dir_l_d;     // pingpong direction, 1 = moving left
  logic [1:0]    speed_q, speed_d;
  logic          paused_q, paused_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          err_q, err_d;
  logic          last_b_q, last_b_d;   // 1 = source B won the last grant

  // Arbiter and decoded command.
  logic          grant_a, grant_b, cmd_valid;
  op_e           cmd_op;
  logic [2:0]    cmd_arg;

  // Derived helpers.
  logic [CW-1:0] last_cnt;
  logic [3:0]    step_led;
  logic          step_dir;
  mode_e         next_mode;

  // State register: every piece of sequencer state, async reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mode_q   <= MODE_RST_E;
      led_q    <= entry_led(MODE_RST_E);
      dir_l_q  <= 1'b1;
      speed_q  <= 2'(SPEED_RST);
      paused_q <= 1'b0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
      last_b_q <= 1'b1;  // B counted as last winner so a tie goes to A first
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      mode_q   <= mode_d;
      led_q    <= led_d;
      dir_l_q  <= dir_l_d;
      speed_q  <= speed_d;
      paused_q <= paused_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
      last_b_q <= last_b_d;
    end
  end

  // Round-robin grant: a lone requester wins, a tie goes to the source not granted last.
  always_comb begin
    grant_a   = a_valid & (~b_valid | last_b_q);
    grant_b   = b_valid & ~grant_a;
    cmd_valid = grant_a | grant_b;
    cmd_op    = op_e'(grant_a ? a_op : b_op);
    cmd_arg   = grant_a ? a_arg : b_arg;
  end

  // Terminal prescaler count for the current speed (period never below one clock).
  always_comb begin
    if ((TICK_BASE >> speed_q) == 0) last_cnt = '0;
    else                             last_cnt = CW'((TICK_BASE >> speed_q) - 1);
  end

  // One pattern step from the current LED value for the current mode.
  always_comb begin
    // NOTE: every signal gets a default first so no latches are inferred.
    step_led = led_q;
    step_dir = dir_l_q;
    case (mode_q)
      M_SHL:   step_led = {led_q[2:0], led_q[3]};
      M_SHR:   step_led = {led_q[0], led_q[3:1]};
      M_PING: begin
        if (dir_l_q) begin
          if (led_q[3]) begin
            step_led = 4'b0100;
            step_dir = 1'b0;
          end else begin
            step_led = {led_q[2:0], 1'b0};
          end
        end else begin
          if (led_q[0]) begin
            step_led = 4'b0010;
            step_dir = 1'b1;
          end else begin
            step_led = {1'b0, led_q[3:1]};
          end
        end
      end
      M_BLINK: step_led = ~led_q;
      default: step_led = led_q;  // OFF holds 0000
    endcase
  end

  // NEXT_MODE successor: 1->2->3->4->1, anything else (OFF) goes to 1.
  always_comb begin
    case (mode_q)
      M_SHL:   next_mode = M_SHR;
      M_SHR:   next_mode = M_PING;
      M_PING:  next_mode = M_BLINK;
      default: next_mode = M_SHL;
    endcase
  end

  // Next-state: an accepted command takes priority over a prescaler step.
  // Any accepted command holds the prescaler unless the command clears it.
  always_comb begin
    mode_d   = mode_q;
    led_d    = led_q;
    dir_l_d  = dir_l_q;
    speed_d  = speed_q;
    paused_d = paused_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    err_d    = 1'b0;
    last_b_d = last_b_q;
    if (cmd_valid) begin
      last_b_d = grant_b;
      case (cmd_op)
        OP_SET_MODE: begin
          if (cmd_arg <= 3'd4) begin
            mode_d  = mode_e'(cmd_arg);
            led_d   = entry_led(mode_e'(cmd_arg));
            dir_l_d = 1'b1;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        OP_SPEED: begin
          speed_d = cmd_arg[1:0];
          cnt_d   = '0;
        end
        OP_PAUSE: paused_d = cmd_arg[0];
        OP_NEXT_MODE: begin
          mode_d  = next_mode;
          led_d   = entry_led(next_mode);
          dir_l_d = 1'b1;
          cnt_d   = '0;
        end
        default: ;
      endcase
    end else if (!paused_q) begin
      if (cnt_q == last_cnt) begin
        cnt_d   = '0;
        led_d   = step_led;
        dir_l_d = step_dir;
        tick_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Outputs: registered state straight out, readies straight from the arbiter.
  always_comb begin
    a_ready  = grant_a;
    b_ready  = grant_b;
    led      = led_q;
    mode_o   = mode_q;
    speed_o  = speed_q;
    paused_o = paused_q;
    tick_o   = tick_q;
    err_o    = err_q;
  end

endmodule

// File: tb/tb_led_pattern_sched.sv
// tb_led_pattern_sched: scoreboard bench. The driver predicts, per cycle, the
// arbiter grants and the registered outputs from a pattern-table model and
// queues them; a negedge monitor pops and compares against the DUT.
module tb_led_pattern_sched;

  localparam int TB_TICK = 8;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic [1:0] a_op = '0, b_op = '0;
  logic [2:0] a_arg = '0, b_arg = '0;
  logic       a_ready, b_ready;
  logic [3:0] led;
  logic [2:0] mode_o;
  logic [1:0] speed_o;
  logic       paused_o, tick_o, err_o;

  led_pattern_sched #(.TICK_BASE(TB_TICK), .MODE_RST(3), .SPEED_RST(0)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .a_valid(a_valid), .a_op(a_op), .a_arg(a_arg), .a_ready(a_ready),
    .b_valid(b_valid), .b_op(b_op), .b_arg(b_arg), .b_ready(b_ready),
    .led(led), .mode_o(mode_o), .speed_o(speed_o), .paused_o(paused_o),
    .tick_o(tick_o), .err_o(err_o)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0] led;
    logic [2:0] mode;
    logic [1:0] speed;
    logic       paused, tick, err, ar, br;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad = 0;
  bit   started = 0;
  bit   done = 0;

  // Reference model: pattern position rather than LED bits.
  int m_mode, m_phase, m_cnt, m_speed;
  bit m_paused, m_last_b, m_tick, m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int seq_len(input int md);
    case (md)
      0:       return 1;
      3:       return 6;
      4:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] seq_led(input int md, input int ph);
    case (md)
      1: return 4'(1 << ph);
      2: return 4'(8 >> ph);
      3: case (ph)
           0: return 4'd1; 1: return 4'd2; 2: return 4'd4;
           3: return 4'd8; 4: return 4'd4; default: return 4'd2;
         endcase
      4: return (ph == 0) ? 4'hF : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  function automatic int period(input int sp);
    int p;
    p = TB_TICK >> sp;
    return (p < 1) ? 1 : p;
  endfunction

  task automatic model_reset();
    m_mode = 3; m_phase = 0; m_cnt = 0; m_speed = 0;
    m_paused = 0; m_last_b = 1; m_tick = 0; m_err = 0;
  endtask

  task automatic push_exp(input bit ga, input bit gb);
    exp_t e;
    e.led = seq_led(m_mode, m_phase);
    e.mode = 3'(m_mode);
    e.speed = 2'(m_speed);
    e.paused = m_paused;
    e.tick = m_tick;
    e.err = m_err;
    e.ar = ga;
    e.br = gb;
    sb_q.push_back(e);
    started = 1;
  endtask

  // One clock: drive inputs just after posedge, predict, advance model, wait next posedge.
  task automatic step_cycle(input bit av, input logic [1:0] ao, input logic [2:0] aa,
                            input bit bv, input logic [1:0] bo, input logic [2:0] ba,
                            output bit ga, output bit gb);
    int op, arg;
    a_valid = av; a_op = ao; a_arg = aa;
    b_valid = bv; b_op = bo; b_arg = ba;
    if (av && bv) begin
      ga = m_last_b; gb = !m_last_b;
    end else begin
      ga = av; gb = bv;
    end
    push_exp(ga, gb);
    m_tick = 0;
    m_err = 0;
    if (ga || gb) begin
      op = ga ? int'(ao) : int'(bo);
      arg = ga ? int'(aa) : int'(ba);
      m_last_b = gb;
      case (op)
        0: if (arg <= 4) begin m_mode = arg; m_phase = 0; m_cnt = 0; end
           else m_err = 1;
        1: begin m_speed = arg % 4; m_cnt = 0; end
        2: m_paused = arg[0];
        default: begin
          m_mode = (m_mode >= 1 && m_mode <= 3) ? m_mode + 1 : 1;
          m_phase = 0; m_cnt = 0;
        end
      endcase
    end else if (!m_paused) begin
      if (m_cnt == period(m_speed) - 1) begin
        m_cnt = 0;
        m_phase = (m_phase + 1) % seq_len(m_mode);
        m_tick = 1;
      end else begin
        m_cnt++;
      end
    end
    @(posedge sys_clk); #1;
  endtask

  task automatic idle(input int n);
    bit ga, gb;
    for (int i = 0; i < n; i++) step_cycle(0, 2'd0, 3'd0, 0, 2'd0, 3'd0, ga, gb);
  endtask

  task automatic send(input bit use_b, input logic [1:0] op, input logic [2:0] arg);
    bit ga, gb;
    if (use_b) step_cycle(0, 2'd0, 3'd0, 1, op, arg, ga, gb);
    else       step_cycle(1, op, arg, 0, 2'd0, 3'd0, ga, gb);
  endtask

  // Advance idle cycles until the model prescaler reaches target (bounded).
  task automatic idle_until_cnt(input int target);
    for (int i = 0; i < 40 && m_cnt != target; i++) idle(1);
  endtask

  // Assert reset between edges, check outputs at once, hold n cycles, release.
  task automatic do_reset(input int n);
    a_valid = 0; b_valid = 0;
    sys_rst_n = 0;
    model_reset();
    #1;
    check("rst_led", led, 4'b0001);
    check("rst_mode", mode_o, 3'd3);
    check("rst_speed", speed_o, 2'd0);
    check("rst_paused", paused_o, 1'b0);
    check("rst_tick", tick_o, 1'b0);
    check("rst_err", err_o, 1'b0);
    for (int i = 0; i < n; i++) begin
      push_exp(0, 0);
      @(posedge sys_clk); #1;
    end
    sys_rst_n = 1;
  endtask

  // Monitor: pops one expectation per cycle and compares at negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge sys_clk);
      if (done) break;
      if (sb_q.size() == 0) begin
        if (started) begin
          total++; bad++;
          $display("FAIL sb_empty: no expectation queued at %0t", $time);
        end
      end else begin
        e = sb_q.pop_front();
        check("led", led, e.led);
        check("mode", mode_o, e.mode);
        check("speed", speed_o, e.speed);
        check("paused", paused_o, e.paused);
        check("tick", tick_o, e.tick);
        check("err", err_o, e.err);
        check("a_ready", a_ready, e.ar);
        check("b_ready", b_ready, e.br);
      end
    end
  end

  // Driver: directed scenarios followed by randomized traffic.
  initial begin
    bit ga, gb, pa, pb;
    logic [1:0] oa, ob;
    logic [2:0] xa, xb;
    model_reset();
    @(posedge sys_clk); #1;
    do_reset(2);
    idle(60);                                // pingpong at speed 0
    send(0, 2'd0, 3'd2);                     // SET_MODE 2 from A
    idle(20);
    for (int i = 0; i < 8; i++)              // contention: grants alternate
      step_cycle(1, 2'd2, 3'd0, 1, 2'd2, 3'd0, ga, gb);
    send(1, 2'd1, 3'd3);                     // SPEED 3
    idle(10);
    send(1, 2'd1, 3'd2);                     // SPEED 2
    idle(10);
    send(0, 2'd1, 3'd0);                     // back to SPEED 0
    idle_until_cnt(5);
    send(0, 2'd2, 3'd1);                     // PAUSE at count 5
    idle(20);
    send(0, 2'd2, 3'd0);                     // resume
    idle(12);
    send(0, 2'd0, 3'd6);                     // illegal SET_MODE
    idle(3);
    send(0, 2'd0, 3'd4);                     // BLINK
    idle(20);
    send(1, 2'd3, 3'd0);                     // NEXT_MODE 4 -> 1
    idle(5);
    idle_until_cnt(TB_TICK - 1);
    send(0, 2'd3, 3'd0);                     // command on terminal count
    idle(10);
    send(0, 2'd2, 3'd1);                     // pause, then change mode
    send(1, 2'd0, 3'd1);
    idle(10);
    send(0, 2'd2, 3'd0);
    idle(10);
    send(0, 2'd0, 3'd0);                     // OFF still ticks
    idle(20);
    send(0, 2'd0, 3'd3);
    idle(13);
    do_reset(1);                             // reset mid-operation
    idle(10);
    pa = 0; pb = 0; oa = '0; ob = '0; xa = '0; xb = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!pa && $urandom_range(0, 9) == 0) begin
        pa = 1; oa = 2'($urandom_range(0, 3)); xa = 3'($urandom_range(0, 7));
      end
      if (!pb && $urandom_range(0, 9) == 0) begin
        pb = 1; ob = 2'($urandom_range(0, 3)); xb = 3'($urandom_range(0, 7));
      end
      step_cycle(pa, oa, xa, pb, ob, xb, ga, gb);
      if (ga) pa = 0;
      if (gb) pb = 0;
    end
    done = 1;
    #20;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
